mem_load_align: RTL and testbench
=================================

# mem_load_align

Load-path alignment stage in the MEM pipeline stage, between the data memory and the 8-bit sign-extension unit. It accepts a load request, runs a read handshake with data memory, and extracts the addressed byte or halfword lane from the 32-bit big-endian memory word. The byte lane feeds the 8-bit sign extender; halfword and word lanes go to their own extenders and writeback. While a read is outstanding it stalls the pipeline, and it flags misaligned and timed-out accesses.

## Interface
- WAIT_MAX, 16: maximum READ cycles without MemAck before a timeout (minimum 2).
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous, active-low reset.
- LoadReq  in  1  load request, level, held by the pipeline while Stall=1.
- LoadType  in  2  00 = byte, 01 = halfword, 10 = word; 11 is reserved and treated as word.
- Addr  in  32  byte address of the load.
- MemRdEn  out  1  read request to data memory.
- MemAddr  out  32  word-aligned read address, {Addr[31:2],2'b00}.
- MemAck  in  1  memory read data valid this cycle.
- MemRdData  in  32  memory read word.
- Stall  out  1  pipeline hold.
- ByteOut  out  8  selected byte lane (to sign extender).
- HalfOut  out  16  selected halfword lane.
- WordOut  out  32  full read word.
- LoadValid  out  1  one-cycle pulse: lane outputs updated.
- AlignErr  out  1  one-cycle pulse: misaligned request rejected.
- TimeoutErr  out  1  one-cycle pulse: no MemAck within WAIT_MAX cycles.

## Operation
- States:
  - IDLE: no access in progress.
  - READ: memory read outstanding.
  - DONE: load result presented.
  - ERR: error reported.
- Requests are accepted in IDLE, DONE and ERR ("accepting states").
- Request acceptance in an accepting state, LoadReq=1:
  - Misaligned request (halfword with Addr[0]=1, or word with Addr[1:0]≠00) → ERR. AlignErr=1 and TimeoutErr=0 in ERR; no memory access is made.
  - Otherwise → READ. Register MemAddr, Addr[1:0] and LoadType; clear the wait counter.
- An accepting state with LoadReq=0 → IDLE.
- READ:
  - MemRdEn=1.
  - MemAck=1 → DONE. Capture:
    - WordOut = MemRdData.
    - ByteOut = lane selected by Addr[1:0]: 00→[31:24], 01→[23:16], 10→[15:8], 11→[7:0].
    - HalfOut = Addr[1] ? [15:0] : [31:16].
    - All three lanes are captured regardless of LoadType.
  - MemAck=0 → wait counter increments. If the counter = WAIT_MAX-1 → ERR with TimeoutErr=1 and AlignErr=0.
  - MemAck in the final allowed cycle wins over the timeout.
- DONE: LoadValid=1.
- ERR: exactly one of AlignErr / TimeoutErr is 1, selected by the cause.
- ByteOut, HalfOut and WordOut hold their value until the next successful capture; errors do not change them.
- MemAck outside READ is ignored.
- Stall = (state==READ) OR (LoadReq AND accepting state AND request aligned). This is combinational.

## Timing
- Reset (Rst=0): immediately, without waiting for a clock:
  - state = IDLE, wait counter = 0.
  - MemRdEn, MemAddr, ByteOut, HalfOut, WordOut, LoadValid, AlignErr and TimeoutErr = 0.
  - Stall = 0 unless the LoadReq term applies.
- Reset during READ aborts the access; MemRdEn drops asynchronously.
- Aligned request accepted at edge 0:
  - READ is entered after edge 0; MemRdEn is high from cycle 1.
  - MemAck sampled at edge k (k≥1) → LoadValid is high in cycle k+1.
  - Minimum latency from request to LoadValid is 2 cycles.
- Misaligned request at edge 0 → AlignErr is high in cycle 1; Stall=0 throughout.
- Timeout: with no MemAck, the READ cycles are 1..WAIT_MAX and TimeoutErr is high in cycle WAIT_MAX+1.
- Back-to-back: a request present during DONE or ERR is accepted at that edge; READ resumes with no idle bubble.

## Test plan
- Reset with LoadReq=0 → all outputs 0, state IDLE. Then byte load of 0x1000_0003 with MemAck in cycle 1 and MemRdData=0x1122_33F4 → MemAddr=0x1000_0000, ByteOut=0xF4, HalfOut=0x33F4, WordOut=0x1122_33F4, LoadValid pulses in cycle 2.
- Halfword load of 0x0000_0002 with MemAck in cycle 4 and data 0xAABB_CCDD → Stall high in cycles 0–4, HalfOut=0xCCDD, LoadValid in cycle 5.
- Halfword load of 0x0000_0001, then word load of 0x0000_0006 → each raises AlignErr for one cycle, MemRdEn stays 0, lane outputs unchanged.
- No MemAck with WAIT_MAX=16 → TimeoutErr in cycle 17, LoadValid stays 0. Repeat with MemAck in cycle 16 → LoadValid and no TimeoutErr.
- Rst pulsed low in cycle 2 of a READ → MemRdEn falls asynchronously and outputs clear. A fresh byte load after reset completes normally.
- Back-to-back byte loads at offsets 0,1,2,3 of word 0x8081_7F00, each with a 1-cycle ack → ByteOut sequence 0x80, 0x81, 0x7F, 0x00, four LoadValid pulses, no idle cycle between accesses.

Source files
------------

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - MEM-stage load alignment: memory read handshake and big-endian lane extraction
module mem_load_align #(
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_req_i,
    input  logic [1:0]  load_type_i,
    input  logic [31:0] addr_i,
    output logic        mem_rd_en_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rd_data_i,
    output logic        stall_o,
    output logic [7:0]  byte_out_o,
    output logic [15:0] half_out_o,
    output logic [31:0] word_out_o,
    output logic        load_valid_o,
    output logic        align_err_o,
    output logic        timeout_err_o
);

    // Counter only ever holds 0..WAIT_MAX-1
    localparam int unsigned CW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state_q;
    logic [CW-1:0] wait_cnt_q;
    logic [1:0]    off_q;
    logic          mem_rd_en_q;
    logic [31:0]   mem_addr_q;
    logic [7:0]    byte_q;
    logic [15:0]   half_q;
    logic [31:0]   word_q;
    logic          load_valid_q;
    logic          align_err_q;
    logic          timeout_err_q;

    logic          accepting;
    logic          misaligned;
    logic [7:0]    byte_d;
    logic [15:0]   half_d;

    // Request qualification and the combinational pipeline hold
    always_comb begin
        accepting  = (state_q != S_READ);
        misaligned = 1'b0;
        case (load_type_i)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr_i[0];
            default: misaligned = (addr_i[1:0] != 2'b00);
        endcase
        stall_o = (state_q == S_READ) | (load_req_i & accepting & ~misaligned);
    end

    // Big-endian lane select from the returning memory word
    always_comb begin
        byte_d = 8'h00;
        case (off_q)
            2'b00: byte_d = mem_rd_data_i[31:24];
            2'b01: byte_d = mem_rd_data_i[23:16];
            2'b10: byte_d = mem_rd_data_i[15:8];
            2'b11: byte_d = mem_rd_data_i[7:0];
        endcase
        half_d = off_q[1] ? mem_rd_data_i[15:0] : mem_rd_data_i[31:16];
    end

    // Load FSM with registered handshake, lane and status outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= '0;
            off_q         <= 2'b00;
            mem_rd_en_q   <= 1'b0;
            mem_addr_q    <= 32'h0;
            byte_q        <= 8'h00;
            half_q        <= 16'h0000;
            word_q        <= 32'h0;
            load_valid_q  <= 1'b0;
            align_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            load_valid_q  <= 1'b0;
            align_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                S_READ: begin
                    if (mem_ack_i) begin
                        // An ack in the last allowed cycle still completes the load
                        state_q      <= S_DONE;
                        mem_rd_en_q  <= 1'b0;
                        word_q       <= mem_rd_data_i;
                        byte_q       <= byte_d;
                        half_q       <= half_d;
                        load_valid_q <= 1'b1;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q       <= S_ERR;
                        mem_rd_en_q   <= 1'b0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (load_req_i) begin
                        if (misaligned) begin
                            state_q     <= S_ERR;
                            align_err_q <= 1'b1;
                        end else begin
                            state_q     <= S_READ;
                            mem_rd_en_q <= 1'b1;
                            mem_addr_q  <= {addr_i[31:2], 2'b00};
                            off_q       <= addr_i[1:0];
                            wait_cnt_q  <= '0;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign mem_rd_en_o   = mem_rd_en_q;
    assign mem_addr_o    = mem_addr_q;
    assign byte_out_o    = byte_q;
    assign half_out_o    = half_q;
    assign word_out_o    = word_q;
    assign load_valid_o  = load_valid_q;
    assign align_err_o   = align_err_q;
    assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_mem_load_align.sv
// tb/tb_mem_load_align.sv - scoreboard bench for mem_load_align
module tb_mem_load_align;

    localparam int WAIT_MAX = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_req;
    logic [1:0]  load_type;
    logic [31:0] addr;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rd_data;
    logic        stall;
    logic [7:0]  byte_out;
    logic [15:0] half_out;
    logic [31:0] word_out;
    logic        load_valid;
    logic        align_err;
    logic        timeout_err;

    always #5 clk = ~clk;

    mem_load_align #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .load_req_i    (load_req),
        .load_type_i   (load_type),
        .addr_i        (addr),
        .mem_rd_en_o   (mem_rd_en),
        .mem_addr_o    (mem_addr),
        .mem_ack_i     (mem_ack),
        .mem_rd_data_i (mem_rd_data),
        .stall_o       (stall),
        .byte_out_o    (byte_out),
        .half_out_o    (half_out),
        .word_out_o    (word_out),
        .load_valid_o  (load_valid),
        .align_err_o   (align_err),
        .timeout_err_o (timeout_err)
    );

    // kind: 0 = load completed, 1 = alignment error, 2 = timeout
    typedef struct {
        int          kind;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  m_b;
    logic [15:0] m_h;
    logic [31:0] m_w;
    exp_t        mon_e;
    int          mon_kind;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_misaligned(input logic [1:0] lt, input logic [31:0] a);
        int size;
        size = (lt == 2'd0) ? 1 : (lt == 2'd1) ? 2 : 4;
        return (a % size) != 0;
    endfunction

    // Issue one request starting in an accepting-state cycle; returns in the DONE/ERR cycle
    task automatic issue(input logic [1:0] lt, input logic [31:0] a, input int ack_cyc,
                         input logic [31:0] d);
        exp_t e;
        bit   mis;
        int   off;
        mis = is_misaligned(lt, a);
        off = int'(a % 4);
        load_req  = 1'b1;
        load_type = lt;
        addr      = a;
        #1;
        chk("stall_accept", {31'b0, stall}, {31'b0, !mis});
        if (mis) begin
            e = '{1, m_b, m_h, m_w};
        end else if (ack_cyc >= 1 && ack_cyc <= WAIT_MAX) begin
            m_w = d;
            m_b = 8'((d >> (8 * (3 - off))) & 32'hFF);
            m_h = 16'((d >> (16 * (1 - off / 2))) & 32'hFFFF);
            e = '{0, m_b, m_h, m_w};
        end else begin
            e = '{2, m_b, m_h, m_w};
        end
        sb_q.push_back(e);
        @(posedge clk); #1;
        load_req = 1'b0;
        #1;
        if (mis) begin
            chk("mis_rden", {31'b0, mem_rd_en}, 32'd0);
            chk("mis_stall", {31'b0, stall}, 32'd0);
            return;
        end
        chk("mem_addr", mem_addr, a - (a % 4));
        for (int c = 1; c <= WAIT_MAX; c++) begin
            chk("rden_read", {31'b0, mem_rd_en}, 32'd1);
            chk("stall_read", {31'b0, stall}, 32'd1);
            if (c == ack_cyc) begin
                mem_ack     = 1'b1;
                mem_rd_data = d;
            end else begin
                mem_ack     = 1'b0;
                mem_rd_data = $urandom;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (c == ack_cyc) return;
        end
    endtask

    // Idle cycles with stray acks that must be ignored
    task automatic idle(input int n);
        repeat (n) begin
            load_req    = 1'b0;
            mem_ack     = 1'($urandom_range(0, 1));
            mem_rd_data = $urandom;
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
    endtask

    // Scoreboard monitor: pop and compare on every reported result
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (load_valid || align_err || timeout_err)) begin
            mon_kind = load_valid ? 0 : (align_err ? 1 : 2);
            chk("pulse_onehot", int'(load_valid) + int'(align_err) + int'(timeout_err), 32'd1);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: kind %0d with no expected entry at %0t",
                         mon_kind, $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk("result_kind", mon_kind, mon_e.kind);
                chk("byte_out", {24'b0, byte_out}, {24'b0, mon_e.b});
                chk("half_out", {16'b0, half_out}, {16'b0, mon_e.h});
                chk("word_out", word_out, mon_e.w);
            end
        end
    end

    logic [31:0] bytes_seq;

    initial begin
        rst_n       = 1'b0;
        load_req    = 1'b0;
        load_type   = 2'b00;
        addr        = 32'h0;
        mem_ack     = 1'b0;
        mem_rd_data = 32'h0;
        m_b = 8'h0; m_h = 16'h0; m_w = 32'h0;
        bytes_seq = 32'h8081_7F00;

        #2;
        chk("rst_rden", {31'b0, mem_rd_en}, 32'd0);
        chk("rst_memaddr", mem_addr, 32'd0);
        chk("rst_word", word_out, 32'd0);
        chk("rst_half", {16'b0, half_out}, 32'd0);
        chk("rst_byte", {24'b0, byte_out}, 32'd0);
        chk("rst_pulses", {29'b0, load_valid, align_err, timeout_err}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Byte load, ack in cycle 1
        issue(2'd0, 32'h1000_0003, 1, 32'h1122_33F4);
        chk("t1_valid", {31'b0, load_valid}, 32'd1);
        chk("t1_byte", {24'b0, byte_out}, 32'hF4);
        chk("t1_half", {16'b0, half_out}, 32'h33F4);
        chk("t1_addr", mem_addr, 32'h1000_0000);
        idle(1);

        // Halfword load, ack in cycle 4
        issue(2'd1, 32'h0000_0002, 4, 32'hAABB_CCDD);
        chk("t2_half", {16'b0, half_out}, 32'hCCDD);
        idle(1);

        // Misaligned halfword then word, back to back
        issue(2'd1, 32'h0000_0001, 0, 32'h0);
        issue(2'd2, 32'h0000_0006, 0, 32'h0);
        chk("t3_word_held", word_out, 32'hAABB_CCDD);
        idle(1);

        // Timeout, then ack in the final allowed cycle
        issue(2'd2, 32'h0000_0100, 0, 32'h0);
        chk("t4_timeout", {31'b0, timeout_err}, 32'd1);
        idle(1);
        issue(2'd2, 32'h0000_0104, WAIT_MAX, 32'hCAFE_F00D);
        chk("t4_late_ack", {30'b0, load_valid, timeout_err}, 32'd2);
        idle(1);

        // Reset in cycle 2 of a read
        load_req = 1'b1; load_type = 2'd0; addr = 32'h0000_0040;
        @(posedge clk); #1;
        load_req = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_rden", {31'b0, mem_rd_en}, 32'd0);
        chk("rst_mid_word", word_out, 32'd0);
        chk("rst_mid_stall", {31'b0, stall}, 32'd0);
        m_b = 8'h0; m_h = 16'h0; m_w = 32'h0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(2'd0, 32'h0000_0041, 2, 32'h0123_4567);
        chk("t5_byte", {24'b0, byte_out}, 32'h23);
        idle(1);

        // Back-to-back byte loads across one word
        for (int off = 0; off < 4; off++) begin
            issue(2'd0, 32'h0000_0200 + 32'(off), 1, 32'h8081_7F00);
            chk("t6_byte", {24'b0, byte_out}, (bytes_seq >> (8 * (3 - off))) & 32'hFF);
        end
        idle(1);

        // Randomized loads
        repeat (150) begin
            int          r;
            int          ack;
            logic [1:0]  lt;
            logic [31:0] a;
            lt = 2'($urandom_range(0, 3));
            a  = $urandom;
            r  = $urandom_range(0, 9);
            ack = (r == 0) ? WAIT_MAX + 1 : (r == 1) ? WAIT_MAX : $urandom_range(1, 4);
            issue(lt, a, ack, $urandom);
            idle($urandom_range(0, 2));
        end

        idle(2);
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
